// File: rtl/brq_mem_arbiter.sv
// Two-into-one req/gnt/rvalid memory port arbiter: instruction fetch and data LSU
// share one port, and in-order responses are routed back by an owner FIFO.
module brq_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        DataPriority   = 1'b0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  instr_req_i,
  output logic                                  instr_gnt_o,
  input  logic [31:0]                           instr_addr_i,
  output logic                                  instr_rvalid_o,
  output logic [31:0]                           instr_rdata_o,
  output logic                                  instr_err_o,
  input  logic                                  data_req_i,
  output logic                                  data_gnt_o,
  input  logic                                  data_we_i,
  input  logic [3:0]                            data_be_i,
  input  logic [31:0]                           data_addr_i,
  input  logic [31:0]                           data_wdata_i,
  output logic                                  data_rvalid_o,
  output logic [31:0]                           data_rdata_o,
  output logic                                  data_err_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic                                  mem_we_o,
  output logic [3:0]                            mem_be_o,
  output logic [31:0]                           mem_addr_o,
  output logic [31:0]                           mem_wdata_o,
  input  logic                                  mem_rvalid_i,
  input  logic [31:0]                           mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  protocol_err_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  logic          r_lock;
  owner_e        r_locked_owner;
  owner_e        r_last_grant;
  owner_e        r_fifo [MaxOutstanding];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_perr;

  logic   w_sel_valid;
  owner_e w_sel;
  logic   w_sel_req;
  logic   w_full;
  logic   w_accept;
  logic   w_pop;
  logic   w_spurious;
  owner_e w_head;

  assign w_full     = (r_count == CW'(MaxOutstanding));
  assign w_pop      = mem_rvalid_i & (r_count != '0);
  assign w_spurious = mem_rvalid_i & (r_count == '0);
  assign w_head     = r_fifo[r_rptr];

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = OWN_INSTR;
    if (r_lock) begin
      w_sel_valid = 1'b1;
      w_sel       = r_locked_owner;
    end else if (instr_req_i && data_req_i) begin
      w_sel_valid = 1'b1;
      w_sel       = DataPriority ? OWN_DATA :
                    ((r_last_grant == OWN_DATA) ? OWN_INSTR : OWN_DATA);
    end else if (data_req_i) begin
      w_sel_valid = 1'b1;
      w_sel       = OWN_DATA;
    end else if (instr_req_i) begin
      w_sel_valid = 1'b1;
      w_sel       = OWN_INSTR;
    end
  end

  always_comb begin
    w_sel_req   = (w_sel == OWN_DATA) ? data_req_i : instr_req_i;
    mem_req_o   = w_sel_valid & w_sel_req & ~w_full;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_sel_valid) begin
      if (w_sel == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
    w_accept    = mem_req_o & mem_gnt_i;
    instr_gnt_o = w_accept & (w_sel == OWN_INSTR);
    data_gnt_o  = w_accept & (w_sel == OWN_DATA);

    instr_rvalid_o = w_pop & (w_head == OWN_INSTR);
    data_rvalid_o  = w_pop & (w_head == OWN_DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    instr_err_o    = instr_rvalid_o & mem_err_i;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    data_err_o     = data_rvalid_o & mem_err_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock         <= 1'b0;
      r_locked_owner <= OWN_INSTR;
      r_last_grant   <= OWN_DATA;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_perr         <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) r_fifo[i] <= OWN_INSTR;
    end else begin
      // Presented-but-ungranted holds the owner; grant or a dropped req both clear it.
      r_lock <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) r_locked_owner <= w_sel;
      if (w_accept) begin
        r_fifo[r_wptr] <= w_sel;
        r_last_grant   <= w_sel;
        if (r_wptr == PW'(MaxOutstanding - 1)) r_wptr <= '0;
        else                                   r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        if (r_rptr == PW'(MaxOutstanding - 1)) r_rptr <= '0;
        else                                   r_rptr <= r_rptr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_spurious) r_perr <= 1'b1;
    end
  end

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Bench for brq_mem_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration and routing rules.
module tb_brq_mem_arbiter;

  localparam int MO = 2;
  localparam bit DP = 1'b0;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  brq_mem_arbiter #(.MaxOutstanding(MO), .DataPriority(DP)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  // Reference model: owner queue, last winner, ungranted-presentation memory.
  bit q_own[$];
  bit m_last, m_lock, m_lock_own, m_perr;
  bit e_have, e_own, e_req, e_we, e_igrant, e_dgrant, e_irv, e_drv, e_ierr, e_derr;
  bit e_accept, e_pop, e_spur;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

  function automatic void model_reset();
    q_own.delete();
    m_last = 1'b1; m_lock = 1'b0; m_lock_own = 1'b0; m_perr = 1'b0;
  endfunction

  function automatic void model_eval();
    bit full;
    full   = (q_own.size() == MO);
    e_have = 1'b1;
    e_own  = 1'b0;
    if (m_lock)                          e_own = m_lock_own;
    else if (instr_req_i && data_req_i)  e_own = DP ? 1'b1 : !m_last;
    else if (data_req_i)                 e_own = 1'b1;
    else if (instr_req_i)                e_own = 1'b0;
    else                                 e_have = 1'b0;
    e_req   = e_have && (e_own ? data_req_i : instr_req_i) && !full;
    e_we    = e_have && e_own && data_we_i;
    e_be    = !e_have ? 4'h0 : (e_own ? data_be_i : 4'hF);
    e_addr  = !e_have ? 32'h0 : (e_own ? data_addr_i : instr_addr_i);
    e_wdata = (e_have && e_own) ? data_wdata_i : 32'h0;
    e_accept = e_req && mem_gnt_i;
    e_igrant = e_accept && !e_own;
    e_dgrant = e_accept && e_own;
    e_pop    = mem_rvalid_i && (q_own.size() != 0);
    e_spur   = mem_rvalid_i && (q_own.size() == 0);
    e_irv    = e_pop && (q_own[0] == 1'b0);
    e_drv    = e_pop && (q_own[0] == 1'b1);
    e_irdata = e_irv ? mem_rdata_i : 32'h0;
    e_drdata = e_drv ? mem_rdata_i : 32'h0;
    e_ierr   = e_irv && mem_err_i;
    e_derr   = e_drv && mem_err_i;
  endfunction

  function automatic void model_commit();
    if (rst_i) begin
      model_reset();
    end else begin
      if (e_pop) void'(q_own.pop_front());
      if (e_spur) m_perr = 1'b1;
      if (e_accept) begin
        q_own.push_back(e_own);
        m_last = e_own;
      end
      m_lock = e_req && !mem_gnt_i;
      if (m_lock) m_lock_own = e_own;
    end
  endfunction

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    settle();
    advance();
    rst_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o, data_gnt_o,
           instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: mem_req=%b be=%h addr=%h gnt=%b%b rv=%b%b, all required 0",
                 mem_req_o, mem_be_o, mem_addr_o, instr_gnt_o, data_gnt_o,
                 instr_rvalid_o, data_rvalid_o);
      end
      advance();
    end
    rst_i = 0;
    settle();
    n_checks++;
    if ({outstanding_o, protocol_err_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_state: outstanding=%0d perr=%b, required 0 0",
               outstanding_o, protocol_err_o);
    end
    advance();
  endtask

  task automatic test_instr_only();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1;
    settle();
    n_checks++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_be_o, mem_addr_o} !== {3'b101, 4'hF, 32'h80}) begin
      n_errors++;
      $display("FAIL instr_grant: gnt=%b%b req=%b be=%h addr=%h, required 10 1 f 00000080",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_be_o, mem_addr_o);
    end
    advance();
    idle_inputs();
    settle(); advance();
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    settle();
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
      n_errors++;
      $display("FAIL instr_response: rv=%b%b irdata=%h drdata=%h, required 10 deadbeef 0",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o);
    end
    advance();
  endtask

  task automatic test_round_robin();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h1000;
    data_req_i = 1; data_addr_i = 32'h2000; data_be_i = 4'h3;
    mem_gnt_i = 1;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid_i = (k > 0);
      mem_rdata_i  = 32'hA0 + k;
      settle();
      n_checks++;
      if ({instr_gnt_o, data_gnt_o} !== {(k % 2 == 0), (k % 2 == 1)}) begin
        n_errors++;
        $display("FAIL rr_grant[%0d]: gnt=%b%b, required %b%b", k, instr_gnt_o, data_gnt_o,
                 (k % 2 == 0), (k % 2 == 1));
      end
      if (k > 0) begin
        n_checks++;
        if ({instr_rvalid_o, data_rvalid_o} !== {((k - 1) % 2 == 0), ((k - 1) % 2 == 1)}) begin
          n_errors++;
          $display("FAIL rr_route[%0d]: rv=%b%b, required %b%b", k, instr_rvalid_o,
                   data_rvalid_o, ((k - 1) % 2 == 0), ((k - 1) % 2 == 1));
        end
      end
      advance();
    end
  endtask

  task automatic test_lock();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h100;
    data_req_i = 1; data_addr_i = 32'h200; data_we_i = 1; data_be_i = 4'h3; data_wdata_i = 32'h55;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if ({mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h100, 2'b00}) begin
        n_errors++;
        $display("FAIL lock_hold[%0d]: req=%b addr=%h gnt=%b%b, required 1 00000100 00",
                 k, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o);
      end
      advance();
    end
    mem_gnt_i = 1;
    settle();
    n_checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin
      n_errors++;
      $display("FAIL lock_grant: gnt=%b%b, required 10", instr_gnt_o, data_gnt_o);
    end
    advance();
    settle();
    n_checks++;
    if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_addr_o} !== {3'b011, 32'h200}) begin
      n_errors++;
      $display("FAIL lock_next: gnt=%b%b we=%b addr=%h, required 01 1 00000200",
               instr_gnt_o, data_gnt_o, mem_we_o, mem_addr_o);
    end
    advance();
    // Data presented alone and stalled must keep the port even when instr would win.
    do_reset();
    data_req_i = 1; data_addr_i = 32'h300; data_be_i = 4'hC;
    settle(); advance();
    instr_req_i = 1; instr_addr_i = 32'h400;
    settle();
    n_checks++;
    if ({mem_addr_o, mem_be_o, instr_gnt_o} !== {32'h300, 4'hC, 1'b0}) begin
      n_errors++;
      $display("FAIL lock_override: addr=%h be=%h igrant=%b, required 00000300 c 0",
               mem_addr_o, mem_be_o, instr_gnt_o);
    end
    advance();
    mem_gnt_i = 1;
    settle();
    n_checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      n_errors++;
      $display("FAIL lock_override_grant: gnt=%b%b, required 01", instr_gnt_o, data_gnt_o);
    end
    advance();
  endtask

  task automatic test_full();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h10; mem_gnt_i = 1;
    settle(); advance();
    settle(); advance();
    settle();
    n_checks++;
    if ({outstanding_o, mem_req_o, instr_gnt_o, data_gnt_o} !== {2'd2, 3'b000}) begin
      n_errors++;
      $display("FAIL full_gate: outstanding=%0d req=%b gnt=%b%b, required 2 0 00",
               outstanding_o, mem_req_o, instr_gnt_o, data_gnt_o);
    end
    mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    settle();
    n_checks++;
    if ({instr_rvalid_o, mem_req_o} !== 2'b10) begin
      n_errors++;
      $display("FAIL full_drain: irv=%b req=%b, required 1 0", instr_rvalid_o, mem_req_o);
    end
    advance();
    mem_rvalid_i = 0;
    settle();
    n_checks++;
    if ({outstanding_o, mem_req_o, instr_gnt_o} !== {2'd1, 2'b11}) begin
      n_errors++;
      $display("FAIL full_reopen: outstanding=%0d req=%b igrant=%b, required 1 1 1",
               outstanding_o, mem_req_o, instr_gnt_o);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h20; mem_gnt_i = 1;
    settle(); advance();
    instr_req_i = 0;
    data_req_i = 1; data_addr_i = 32'h24; data_be_i = 4'h1;
    mem_rvalid_i = 1; mem_rdata_i = 32'h1234; mem_err_i = 1;
    settle();
    n_checks++;
    if ({instr_rvalid_o, instr_err_o, data_rvalid_o, data_gnt_o, instr_rdata_o} !== {4'b1101, 32'h1234}) begin
      n_errors++;
      $display("FAIL simul_route: irv=%b ierr=%b drv=%b dgnt=%b irdata=%h, required 1 1 0 1 00001234",
               instr_rvalid_o, instr_err_o, data_rvalid_o, data_gnt_o, instr_rdata_o);
    end
    advance();
    idle_inputs();
    settle();
    n_checks++;
    if (outstanding_o !== 2'd1) begin
      n_errors++;
      $display("FAIL simul_count: outstanding=%0d, required 1", outstanding_o);
    end
    advance();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
    settle();
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL spur_drop: rv=%b%b, required 00", instr_rvalid_o, data_rvalid_o);
    end
    advance();
    idle_inputs();
    instr_req_i = 1; mem_gnt_i = 1;
    settle(); advance();
    idle_inputs();
    settle();
    n_checks++;
    if ({protocol_err_o, outstanding_o} !== {1'b1, 2'd1}) begin
      n_errors++;
      $display("FAIL spur_sticky: perr=%b outstanding=%0d, required 1 1",
               protocol_err_o, outstanding_o);
    end
    rst_i = 1;
    settle(); advance();
    rst_i = 0;
    mem_rvalid_i = 1;
    settle();
    n_checks++;
    if ({protocol_err_o, outstanding_o, instr_rvalid_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_midflight: perr=%b outstanding=%0d irv=%b, required 0 0 0",
               protocol_err_o, outstanding_o, instr_rvalid_o);
    end
    advance();
    idle_inputs();
    settle();
    n_checks++;
    if (protocol_err_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stale_response: perr=%b, required 1", protocol_err_o);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_i        = ($urandom_range(99) == 0);
      instr_req_i  = $urandom_range(1);
      instr_addr_i = $urandom;
      data_req_i   = $urandom_range(1);
      data_we_i    = $urandom_range(1);
      data_be_i    = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
      mem_gnt_i    = ($urandom_range(2) != 0);
      mem_rvalid_i = ($urandom_range(9) < 4);
      mem_rdata_i  = $urandom;
      mem_err_i    = ($urandom_range(7) == 0);
      settle();
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
          {e_req, e_we, e_be, e_addr, e_wdata}) begin
        n_errors++;
        $display("FAIL rand_port[%0d]: req=%b we=%b be=%h addr=%h wd=%h, required %b %b %h %h %h",
                 c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                 e_req, e_we, e_be, e_addr, e_wdata);
      end
      n_checks++;
      if ({instr_gnt_o, data_gnt_o} !== {e_igrant, e_dgrant}) begin
        n_errors++;
        $display("FAIL rand_grant[%0d]: gnt=%b%b, required %b%b", c, instr_gnt_o, data_gnt_o,
                 e_igrant, e_dgrant);
      end
      n_checks++;
      if ({instr_rvalid_o, instr_err_o, instr_rdata_o, data_rvalid_o, data_err_o, data_rdata_o} !==
          {e_irv, e_ierr, e_irdata, e_drv, e_derr, e_drdata}) begin
        n_errors++;
        $display("FAIL rand_resp[%0d]: i=%b%b %h d=%b%b %h, required i=%b%b %h d=%b%b %h", c,
                 instr_rvalid_o, instr_err_o, instr_rdata_o, data_rvalid_o, data_err_o,
                 data_rdata_o, e_irv, e_ierr, e_irdata, e_drv, e_derr, e_drdata);
      end
      n_checks++;
      if (int'(outstanding_o) !== q_own.size() || protocol_err_o !== m_perr) begin
        n_errors++;
        $display("FAIL rand_state[%0d]: outstanding=%0d perr=%b, required %0d %b", c,
                 outstanding_o, protocol_err_o, q_own.size(), m_perr);
      end
      advance();
    end
    rst_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_instr_only();
    test_round_robin();
    test_lock();
    test_full();
    test_simultaneous();
    test_spurious_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/brq_mem_arbiter.md
Name: brq_mem_arbiter

Overview:
Shares one req/gnt/rvalid memory port between the core instruction-fetch and data-LSU interfaces, so both can use a single tlul_host_adapter and TL-UL host port. It sits between the core and the adapter. It arbitrates requests, holds the selection stable across an ungranted handshake, and tracks in-order outstanding transactions so each response is routed back to the requester that issued it.

Parameters:
MaxOutstanding, 2, depth of the outstanding-owner FIFO and the maximum number of in-flight accepted requests (>=1)
DataPriority, 1'b0, 0 = round-robin arbitration; 1 = data always wins contention

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
instr_req_i  input  1  fetch request
instr_gnt_o  output  1  fetch request accepted
instr_addr_i  input  32  fetch address
instr_rvalid_o  output  1  fetch response valid
instr_rdata_o  output  32  fetch response data
instr_err_o  output  1  fetch response error
data_req_i  input  1  LSU request
data_gnt_o  output  1  LSU request accepted
data_we_i  input  1  LSU write enable
data_be_i  input  4  LSU byte enables
data_addr_i  input  32  LSU address
data_wdata_i  input  32  LSU write data
data_rvalid_o  output  1  LSU response valid
data_rdata_o  output  32  LSU response data
data_err_o  output  1  LSU response error
mem_req_o  output  1  shared port request
mem_gnt_i  input  1  shared port grant
mem_we_o  output  1  shared write enable
mem_be_o  output  4  shared byte enables
mem_addr_o  output  32  shared address
mem_wdata_o  output  32  shared write data
mem_rvalid_i  input  1  shared response valid
mem_rdata_i  input  32  shared response data
mem_err_i  input  1  shared response error
outstanding_o  output  $clog2(MaxOutstanding+1)  in-flight accepted-request count
protocol_err_o  output  1  sticky: response arrived with no outstanding request

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high. Reset clears the owner FIFO, lock, count and protocol_err_o, and sets last_grant to DATA so that instr wins the first contention.
- Reset values: all outputs 0 during and after reset until a request or response arrives.
- Owner selection:
  - If lock is set, select locked_owner.
  - Otherwise, if only one requester is active, select it.
  - If both are active: DataPriority=1 selects data; DataPriority=0 selects the opposite of last_grant.
- Full gating: when outstanding_o == MaxOutstanding, mem_req_o = 0 and no grants are issued.
- Request forwarding is combinational with zero latency:
  - mem_req_o = selected requester's req & !full.
  - mem_addr/we/be/wdata come from the selected requester. Instr drives we=0, be=4'hF, wdata=0.
  - Outputs are 0 when no requester is selected.
- Grants: sel_gnt_o = mem_gnt_i & mem_req_o & (sel==owner). The unselected requester's gnt is always 0.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, register lock=1 and locked_owner=sel. The same requester is presented until granted, even if the other requester has priority.
  - Lock clears in the grant cycle.
  - If the locked requester drops req (protocol violation), lock clears the next cycle.
- Accept: on mem_req_o & mem_gnt_i, push the owner bit into the FIFO and set last_grant=owner.
- Responses (in order):
  - On mem_rvalid_i with the FIFO non-empty, pulse the head owner's rvalid_o, drive its rdata/err from mem_*, and pop. The other requester's rvalid is 0.
  - rdata/err outputs are 0 when the corresponding rvalid is 0.
- Same-cycle accept and response: push and pop both occur and the count is unchanged. A grant and a response may target the same or different requesters.
- Spurious response: mem_rvalid_i with an empty FIFO is dropped (no rvalid_o) and sets protocol_err_o until reset.
- Reset mid-operation: in-flight ownership is discarded. Responses to pre-reset requests are treated as spurious.
- Pointers wrap modulo MaxOutstanding. The count is exact and never exceeds MaxOutstanding.

Test Plan:
- Instr only: instr_req=1, addr=0x80, mem_gnt=1 same cycle → instr_gnt=1 that cycle, mem_addr=0x80, mem_be=F. mem_rvalid with rdata=0xDEADBEEF two cycles later → instr_rvalid=1, instr_rdata=0xDEADBEEF, data_rvalid=0.
- Round-robin (DataPriority=0): both requesting continuously, mem_gnt=1, immediate responses → grants alternate instr, data, instr, data starting with instr after reset. Responses route in the same order.
- Lock: both requesting, mem_gnt=0 for 3 cycles → mem_addr stays the instr address throughout. Grant in cycle 4 goes to instr; data is granted on the next accept.
- Full: MaxOutstanding=2, two accepts with no response → outstanding_o=2, mem_req_o=0, no gnt. One rvalid → outstanding_o=1 and the next request is granted the following cycle.
- Simultaneous: accept data while the response for an earlier instr request arrives → instr_rvalid=1, data_gnt=1, outstanding_o unchanged.
- Spurious and reset: mem_rvalid_i with outstanding_o=0 → no rvalid_o, protocol_err_o=1. Asserting rst_i with 1 outstanding → outstanding_o=0 and protocol_err_o=0 next cycle.
